rf_sweeper: RTL

Port-side controller for the 32×24 dual-port `reg_file`: drives write port A and read port B. Three jobs: forwards host writes to port A while idle; on command, zero-fills every entry through port A; on command, reads every entry through port B and streams `{addr, data}` out over a valid/ready interface for debug dump. Sits between the processor/debug logic and `reg_file`, with `clka` and `clkb` tied to the same `clk`.

---
 rtl/rf_sweeper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rf_sweeper.sv
// rf_sweeper: port-side controller for the dual-port register file.
// Forwards host writes to port A while idle, zero-fills every entry through
// port A, and streams every entry read through port B out over valid/ready.
module rf_sweeper #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    input  logic              start_clear,
    input  logic              start_dump,
    output logic              busy,
    output logic              done,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_OUT     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addrb_q, addrb_d;
    logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
    logic [DATA_W-1:0]   odata_q, odata_d;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            addrb_q <= '0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addrb_q <= addrb_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
        end
    end

    // Next-state logic: sequencing of clear and dump, pointer and read capture.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        addrb_d = addrb_q;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_clear) begin
                    ptr_d   = '0;
                    state_d = S_CLR;
                end else if (start_dump) begin
                    ptr_d   = '0;
                    addrb_d = '0;
                    state_d = S_RD_ADDR;
                end
            end
            S_CLR: begin
                // Stop by compare on the last entry rather than relying on wrap.
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            S_RD_ADDR: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    odata_d = doutb;
                    oaddr_d = ptr_q;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        // addrb moves only here so it is stable RD_ADDR..OUT.
                        ptr_d   = ptr_q + ADDR_W'(1);
                        addrb_d = ptr_q + ADDR_W'(1);
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: port A is host-driven in IDLE and pointer-driven in CLR.
    always_comb begin
        wea       = 1'b0;
        addra     = '0;
        dina      = '0;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        out_valid = (state_q == S_OUT);
        unique case (state_q)
            S_IDLE: begin
                // A start command in the same cycle takes priority over the write.
                wea   = host_we & ~start_clear & ~start_dump;
                addra = host_addr;
                dina  = host_din;
            end
            S_CLR: begin
                wea   = 1'b1;
                addra = ptr_q;
                dina  = '0;
            end
            default: begin
                wea = 1'b0;
            end
        endcase
    end

    assign addrb    = addrb_q;
    assign out_addr = oaddr_q;
    assign out_data = odata_q;

endmodule
